// File: rtl/udp_rx_packet_buffer_if.sv
// Bus bundle for udp_rx_packet_buffer: UDP receive byte stream (no backpressure) plus the
// 8-bit AXI-Stream output. The slave modport is the buffer's view, master the environment's.
interface udp_rx_packet_buffer_if;
   logic        udp_in_start;
   logic [15:0] udp_in_dst_port;
   logic [7:0]  udp_in_data;
   logic        udp_in_valid;
   logic        udp_in_last;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;

   modport master (
      output udp_in_start, udp_in_dst_port, udp_in_data, udp_in_valid, udp_in_last, m_axis_tready,
      input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
   modport slave (
      input  udp_in_start, udp_in_dst_port, udp_in_data, udp_in_valid, udp_in_last, m_axis_tready,
      output m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/udp_rx_packet_buffer.sv
// Store-and-forward UDP receive buffer: releases only complete datagrams on AXI-Stream, drops
// datagrams that do not fit. Define UDP_RX_BUF_STATS_EN to build the pkt/drop counters.
module udp_rx_packet_buffer #(
   parameter int unsigned PORT      = 18520,
   parameter int unsigned ADDR_BITS = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   udp_rx_packet_buffer_if.slave bus,
   output logic [7:0]            pkt_count,
   output logic [7:0]            drop_count
);
   localparam int unsigned DEPTH = 1 << ADDR_BITS;
   typedef logic [ADDR_BITS:0] ptr_t;
   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   state_t               state_q, state_d;
   ptr_t                 wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
   ptr_t                 commit_rd_q, rd_ptr_q, rd_ptr_d;
   logic                 tvalid_q, tvalid_d;
   logic [8:0]           out_q, out_d;
   logic                 we, load, pkt_inc;
   logic [1:0]           drop_inc;
   logic [ADDR_BITS-1:0] waddr;
   logic [8:0]           mem [DEPTH];

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      we           = 1'b0;
      pkt_inc      = 1'b0;
      drop_inc     = 2'd0;
      if (bus.udp_in_start) begin
         // a header mid-datagram truncates it; the new header is then judged as if idle
         if (state_q != IDLE) begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = 2'd1;
         end
         state_d = (enable && bus.udp_in_dst_port == 16'(PORT)) ? RECV : IDLE;
      end
      waddr = wr_ptr_d[ADDR_BITS-1:0];
      if (bus.udp_in_valid) begin
         case (state_d)
            RECV: begin
               if (ptr_t'(wr_ptr_d - rd_ptr_q) == ptr_t'(DEPTH)) begin
                  if (bus.udp_in_last) begin
                     wr_ptr_d = commit_ptr_q;
                     drop_inc = drop_inc + 2'd1;
                     state_d  = IDLE;
                  end else begin
                     state_d = DROP;
                  end
               end else begin
                  we       = 1'b1;
                  wr_ptr_d = wr_ptr_d + ptr_t'(1);
                  if (bus.udp_in_last) begin
                     commit_ptr_d = wr_ptr_d;
                     pkt_inc      = 1'b1;
                     state_d      = IDLE;
                  end
               end
            end
            DROP: begin
               if (bus.udp_in_last) begin
                  wr_ptr_d = commit_ptr_q;
                  drop_inc = drop_inc + 2'd1;
                  state_d  = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Read side sees the commit pointer one cycle late, so output follows the last byte by two edges.
   always_comb begin
      load     = (rd_ptr_q != commit_rd_q) && (!tvalid_q || bus.m_axis_tready);
      rd_ptr_d = load ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
      tvalid_d = load || (tvalid_q && !bus.m_axis_tready);
      out_d    = load ? mem[rd_ptr_q[ADDR_BITS-1:0]] : out_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         commit_rd_q  <= '0;
         rd_ptr_q     <= '0;
         tvalid_q     <= 1'b0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         commit_rd_q  <= commit_ptr_q;
         rd_ptr_q     <= rd_ptr_d;
         tvalid_q     <= tvalid_d;
         out_q        <= out_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= {bus.udp_in_last, bus.udp_in_data};
   end

   assign bus.m_axis_tdata  = out_q[7:0];
   assign bus.m_axis_tlast  = out_q[8];
   assign bus.m_axis_tvalid = tvalid_q;

`ifdef UDP_RX_BUF_STATS_EN
   logic [7:0] pkt_count_q, pkt_count_d, drop_count_q, drop_count_d;
   logic [8:0] drop_sum;

   always_comb begin
      pkt_count_d  = (pkt_inc && pkt_count_q != 8'hFF) ? pkt_count_q + 8'd1 : pkt_count_q;
      drop_sum     = {1'b0, drop_count_q} + {7'd0, drop_inc};
      drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         pkt_count_q  <= pkt_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign pkt_count  = pkt_count_q;
   assign drop_count = drop_count_q;
`else
   logic unused_stats;
   assign unused_stats = ^{pkt_inc, drop_inc};
   assign pkt_count    = '0;
   assign drop_count   = '0;
`endif
endmodule
